// File: rtl/pll_clk_ctrl_pkg.sv
// Shared types and helpers for the PLL clock-enable / reset sequencer.
package pll_clk_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    ENABLE    = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_t;

  localparam int LOST_CNT_W = 8;

  // Width able to hold values up to (largest cycle parameter - 1).
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_clk_ctrl_lock_sync.sv
// Two-flop synchronizer for the raw PLL lock plus a consecutive-sample debounce.
module pll_lock_sync #(
  parameter int LOCK_FILTER = 4
) (
  input  logic clkin,
  input  logic reset,
  input  logic pll_lock,
  output logic lock_ok
);

  localparam int FW = (LOCK_FILTER < 2) ? 1 : $clog2(LOCK_FILTER);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);

  logic          lock_p0;
  logic          lock_p1;
  logic [FW-1:0] hi_cnt;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
      hi_cnt  <= '0;
    end else begin
      lock_p0 <= pll_lock;
      lock_p1 <= lock_p0;
      if (!lock_p1)
        hi_cnt <= '0;
      else if (hi_cnt < FILT_LAST)
        hi_cnt <= hi_cnt + FW'(1);
    end
  end

  // hi_cnt counts earlier high samples, so the current one completes the run.
  assign lock_ok = lock_p1 && (hi_cnt >= FILT_LAST);

endmodule

// File: rtl/pll_clk_ctrl.sv
// PLL consumer-side sequencer: lock filter, staggered clock enables, system reset.
// Optional build macro PLL_CLK_CTRL_RELOCK_EN: lock loss in RUN re-sequences instead of faulting.
module pll_clk_ctrl
  import pll_clk_ctrl_pkg::*;
#(
  parameter int NUM_CLK        = 5,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_FILTER    = 4,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic                  clkin,
  input  logic                  reset,
  input  logic                  pll_lock,
  input  logic [NUM_CLK-1:0]    en_req,
  input  logic                  restart,
  output logic                  pll_reset,
  output logic [NUM_CLK-1:0]    enclk,
  output logic                  sys_rst,
  output logic                  ready,
  output logic                  fault,
  output logic [LOST_CNT_W-1:0] lock_lost_cnt
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES, STAGGER_CYCLES);
  localparam int IDX_W = (NUM_CLK < 2) ? 1 : $clog2(NUM_CLK);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLK - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             lock_ok;

  pll_lock_sync #(
    .LOCK_FILTER (LOCK_FILTER)
  ) u_lock_sync (
    .clkin    (clkin),
    .reset    (reset),
    .pll_lock (pll_lock),
    .lock_ok  (lock_ok)
  );

  assign idx_nxt = idx + IDX_W'(1);

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state         <= RESET_PLL;
      cnt           <= '0;
      idx           <= '0;
      pll_reset     <= 1'b1;
      enclk         <= '0;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      fault         <= 1'b0;
      lock_lost_cnt <= '0;
    end else begin
      // Loss counting is independent of restart so a coincident pulse still counts.
      if (state == RUN && !lock_ok && lock_lost_cnt != '1)
        lock_lost_cnt <= lock_lost_cnt + LOST_CNT_W'(1);

      if (restart) begin
        state     <= RESET_PLL;
        cnt       <= '0;
        idx       <= '0;
        pll_reset <= 1'b1;
        enclk     <= '0;
        sys_rst   <= 1'b1;
        ready     <= 1'b0;
        fault     <= 1'b0;
      end else begin
        case (state)
          RESET_PLL: begin
            if (cnt == RST_LAST) begin
              state     <= WAIT_LOCK;
              pll_reset <= 1'b0;
              cnt       <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          WAIT_LOCK: begin
            if (lock_ok) begin
              // The cycle lock_ok was seen counts as the first settle cycle.
              state <= SETTLE;
              cnt   <= CNT_W'(1);
            end else if (cnt == TMO_LAST) begin
              state     <= FAULT;
              pll_reset <= 1'b1;
              fault     <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          SETTLE: begin
            if (!lock_ok) begin
              state     <= RESET_PLL;
              pll_reset <= 1'b1;
              cnt       <= '0;
            end else if (cnt >= SET_LAST) begin
              state    <= ENABLE;
              cnt      <= '0;
              idx      <= '0;
              enclk[0] <= en_req[0];
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ENABLE: begin
            if (!lock_ok) begin
              state     <= RESET_PLL;
              pll_reset <= 1'b1;
              enclk     <= '0;
              cnt       <= '0;
              idx       <= '0;
            end else if (cnt == STG_LAST) begin
              cnt <= '0;
              if (idx == IDX_LAST) begin
                state   <= RUN;
                ready   <= 1'b1;
                sys_rst <= 1'b0;
              end else begin
                idx            <= idx_nxt;
                enclk[idx_nxt] <= en_req[idx_nxt];
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RUN: begin
            if (!lock_ok) begin
              enclk     <= '0;
              sys_rst   <= 1'b1;
              ready     <= 1'b0;
              pll_reset <= 1'b1;
              cnt       <= '0;
              idx       <= '0;
`ifdef PLL_CLK_CTRL_RELOCK_EN
              state     <= RESET_PLL;
`else
              state     <= FAULT;
              fault     <= 1'b1;
`endif
            end else begin
              enclk <= en_req;
            end
          end
          FAULT: begin
            pll_reset <= 1'b1;
            enclk     <= '0;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b1;
          end
          default: begin
            state     <= RESET_PLL;
            cnt       <= '0;
            pll_reset <= 1'b1;
            enclk     <= '0;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_clk_ctrl.sv
// Directed bench for pll_clk_ctrl with shortened cycle parameters.
module tb_pll_clk_ctrl;
  import pll_clk_ctrl_pkg::*;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic [4:0] en_req = '0;
  logic       restart = 1'b0;
  logic       pll_reset;
  logic [4:0] enclk;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [7:0] lock_lost_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  pll_clk_ctrl #(
    .NUM_CLK        (5),
    .PLL_RST_CYCLES (4),
    .LOCK_FILTER    (3),
    .LOCK_TIMEOUT   (100),
    .SETTLE_CYCLES  (10),
    .STAGGER_CYCLES (2)
  ) dut (
    .clkin         (clkin),
    .reset         (reset),
    .pll_lock      (pll_lock),
    .en_req        (en_req),
    .restart       (restart),
    .pll_reset     (pll_reset),
    .enclk         (enclk),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .fault         (fault),
    .lock_lost_cnt (lock_lost_cnt)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic release_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      step();
      n++;
    end
    chk(tag, 32'(ready), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_reset"}, 32'(pll_reset), 32'd1);
    chk({tag, "_enclk"}, 32'(enclk), 32'd0);
    chk({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_lost_cnt"}, 32'(lock_lost_cnt), 32'd0);
    chk({tag, "_state"}, 32'(dut.state), 32'(RESET_PLL));
  endtask

  initial begin
    bit seen;

    // Reset state
    step();
    step();
    chk_reset_vals("rst");

    // Normal bring-up
    en_req = 5'b10111;
    release_reset();
    step_to(3);
    chk("pll_reset_c3", 32'(pll_reset), 32'd1);
    step_to(4);
    chk("pll_reset_c4", 32'(pll_reset), 32'd0);
    step_to(20);
    pll_lock = 1'b1;
    step_to(23);
    chk("lock_ok_c23", 32'(dut.lock_ok), 32'd0);
    step_to(24);
    chk("lock_ok_c24", 32'(dut.lock_ok), 32'd1);
    step_to(33);
    chk("enclk_c33", 32'(enclk), 32'h00);
    step_to(34);
    chk("enclk_c34", 32'(enclk), 32'h01);
    step_to(36);
    chk("enclk_c36", 32'(enclk), 32'h03);
    step_to(38);
    chk("enclk_c38", 32'(enclk), 32'h07);
    step_to(40);
    chk("enclk_c40", 32'(enclk), 32'h07);
    step_to(42);
    chk("enclk_c42", 32'(enclk), 32'h17);
    step_to(43);
    chk("ready_c43", 32'(ready), 32'd0);
    chk("sys_rst_c43", 32'(sys_rst), 32'd1);
    step_to(44);
    chk("ready_c44", 32'(ready), 32'd1);
    chk("sys_rst_c44", 32'(sys_rst), 32'd0);
    chk("enclk_c44", 32'(enclk), 32'h17);
    step_to(45);
    en_req = 5'b01010;
    chk("enclk_c45", 32'(enclk), 32'h17);
    step_to(46);
    chk("enclk_c46", 32'(enclk), 32'h0a);

    // Lock loss in RUN
    step_to(50);
    pll_lock = 1'b0;
    step_to(52);
    chk("loss_ready_c52", 32'(ready), 32'd1);
    chk("loss_enclk_c52", 32'(enclk), 32'h0a);
    step_to(53);
    chk("loss_enclk_c53", 32'(enclk), 32'h00);
    chk("loss_ready_c53", 32'(ready), 32'd0);
    chk("loss_sys_rst_c53", 32'(sys_rst), 32'd1);
    chk("loss_cnt_c53", 32'(lock_lost_cnt), 32'd1);
    chk("loss_pll_reset_c53", 32'(pll_reset), 32'd1);
    pll_lock = 1'b1;
`ifdef PLL_CLK_CTRL_RELOCK_EN
    chk("loss_fault_c53", 32'(fault), 32'd0);
    chk("loss_state_c53", 32'(dut.state), 32'(RESET_PLL));
`else
    chk("loss_fault_c53", 32'(fault), 32'd1);
    step_to(93);
    chk("loss_hold_fault", 32'(fault), 32'd1);
    chk("loss_hold_ready", 32'(ready), 32'd0);
    chk("loss_hold_enclk", 32'(enclk), 32'h00);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("loss_restart_fault", 32'(fault), 32'd0);
    chk("loss_restart_state", 32'(dut.state), 32'(RESET_PLL));
`endif
    wait_ready("loss_reseq_ready");
    chk("loss_reseq_enclk", 32'(enclk), 32'h0a);
    chk("loss_reseq_cnt", 32'(lock_lost_cnt), 32'd1);

    // Lock timeout
    pll_lock = 1'b0;
    release_reset();
    step_to(103);
    chk("tmo_fault_c103", 32'(fault), 32'd0);
    chk("tmo_pll_reset_c103", 32'(pll_reset), 32'd0);
    step_to(104);
    chk("tmo_fault_c104", 32'(fault), 32'd1);
    chk("tmo_pll_reset_c104", 32'(pll_reset), 32'd1);
    chk("tmo_sys_rst_c104", 32'(sys_rst), 32'd1);
    step_to(110);
    chk("tmo_fault_hold", 32'(fault), 32'd1);
    restart = 1'b1;
    step_to(111);
    restart = 1'b0;
    chk("tmo_restart_fault", 32'(fault), 32'd0);
    chk("tmo_restart_pll_reset", 32'(pll_reset), 32'd1);
    chk("tmo_restart_state", 32'(dut.state), 32'(RESET_PLL));

    // Glitch filtering: two-cycle pulse on the raw lock
    release_reset();
    step_to(10);
    pll_lock = 1'b1;
    step_to(12);
    pll_lock = 1'b0;
    seen = 1'b0;
    while (cyc < 30) begin
      step();
      if (dut.lock_ok) seen = 1'b1;
    end
    chk("glitch_lock_ok", 32'(seen), 32'd0);
    chk("glitch_state", 32'(dut.state), 32'(WAIT_LOCK));

    // Reset asserted mid-ENABLE (step 2)
    en_req = 5'b10111;
    release_reset();
    step_to(20);
    pll_lock = 1'b1;
    step_to(39);
    chk("midenable_state", 32'(dut.state), 32'(ENABLE));
    chk("midenable_enclk", 32'(enclk), 32'h07);
    reset = 1'b1;
    #1;
    chk_reset_vals("midenable_rst");

    // Loss counter saturation
    en_req = 5'b11111;
    release_reset();
    for (int i = 0; i < 256; i++) begin
      wait_ready("sat_ready");
      pll_lock = 1'b0;
      step();
      pll_lock = 1'b1;
      step();
      step();
      step();
      restart = 1'b1;
      step();
      restart = 1'b0;
      if (i == 0) chk("sat_cnt_1", 32'(lock_lost_cnt), 32'd1);
      if (i == 254) chk("sat_cnt_255", 32'(lock_lost_cnt), 32'd255);
    end
    chk("sat_cnt_hold", 32'(lock_lost_cnt), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
